sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares the single `sram_driver` instance between two requesters, e.g. the serial command decoder on port 0 and a memory test/scan engine on port 1. It arbitrates round-robin and registers the winner's command. It sequences the driver's start/ready handshake, then returns read data with a one-cycle acknowledge. It sits between the requesters and the `sram_driver` module interface; the SRAM pins are untouched.

## Interface
- `TIMEOUT`, default 1023: driver-busy cycles before abort. Used only with `SRAM_ARB_TIMEOUT_EN`.
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high
- `req0`, `req1`  in  1  level request; hold until ack
- `we0`, `we1`  in  1  1 = write, 0 = read; stable while req
- `addr0`, `addr1`  in  13  SRAM address; stable while req
- `wdata0`, `wdata1`  in  8  write data; stable while req
- `ack0`, `ack1`  out  1  one-cycle completion pulse
- `rdata0`, `rdata1`  out  8  read data; valid from ack, held until that port's next ack
- `err0`, `err1`  out  1  timeout flag, coincident with ack; tied 0 without the macro
- `busy`  out  1  high in every state except IDLE
- `drv_start`  out  1  to driver `start`
- `drv_re`  out  1  to driver `re`
- `drv_address`  out  13  to driver `address`
- `drv_data_write`  out  8  to driver `data_write`
- `drv_ready`  in  1  from driver `ready`
- `drv_data_read`  in  8  from driver `data_read`

Reset values:
- `drv_re` = 1 (read, safe).
- All other outputs 0: `drv_start`, `drv_address`, `drv_data_write`, `ack*`, `err*`, `rdata*`, `busy`.

## Operation
FSM states: IDLE, START, ACKWAIT, BUSY, DONE.
- **IDLE → START**: when `drv_ready`=1 and any `req` is high.
  - Winner is chosen by round-robin. `last` register resets to 1, so port 0 wins the first tie.
  - Register the winner's `we`/`addr`/`wdata` into `drv_re`=!we, `drv_address`, `drv_data_write`.
  - Record grant index; set `last` to the winner.
- **START**: `drv_start`=1 for exactly this cycle → ACKWAIT.
- **ACKWAIT**: wait for `drv_ready`=0 → BUSY. The driver drops ready one cycle or more after start, so ready is not trusted in START.
- **BUSY**: wait for `drv_ready`=1 → DONE.
- **DONE**: one cycle, then → IDLE.
  - If the op was a read, capture `drv_data_read` into the granted port's `rdata`.
  - Pulse the granted port's `ack`.
- **Single requester**: always wins; there is no fairness penalty.
- **Simultaneous requests**: grant goes to the port that is not `last`.
- **Requester handshake**:
  - The requester deasserts `req` on the edge at which it samples `ack`.
  - `req` still high in the cycle after DONE is a new request.
- **`req` dropped after grant**: the transaction completes and `ack` still pulses.
- **`drv_re`/`drv_address`/`drv_data_write`**: hold their last values in IDLE.
- **Reset mid-operation**: FSM → IDLE and all outputs go to reset values next edge. No ack is issued. The driver shares `reset`.

## Timing
- **Latency**: `req` sampled in IDLE at cycle 0 → `drv_start` cycle 1 → ack at cycle 1 + N + 2 at minimum. N is the number of driver busy cycles (ready low).
- **`ack` and `rdata`**: both registered; `rdata` is updated on the same edge that raises `ack`.
- **Back-to-back**: the next grant is no earlier than the cycle after DONE.
- **`busy`**: registered; high from START through DONE inclusive.

## Configuration
- `SRAM_ARB_TIMEOUT_EN` defined:
  - Counter of width $clog2(TIMEOUT+1) clears in START and increments in ACKWAIT and BUSY.
  - When it reaches `TIMEOUT`, → DONE with `err`=1 and `ack`=1 for the granted port, and that port's `rdata` is set to 8'h00.
  - Late driver ready is ignored; the next IDLE still requires `drv_ready`=1.
- Undefined: no counter, and `err0`/`err1` are constant 0. A hung driver stalls the arbiter indefinitely.

## Structure
- Package `sram_arb_pkg` holds:
  - FSM state encoding.
  - `SRAM_ADDR_W`=13 and `SRAM_DATA_W`=8.
  - Port index constants `PORT_SERIAL`=0 and `PORT_SCAN`=1.
- Sub-module `rr_arbiter2`: combinational two-way round-robin pick.
  - Inputs: `req[1:0]`, `last`.
  - Outputs: `grant_idx`, `grant_valid`.
  - The `last` register lives in `sram_arbiter`.

## Test plan
- **Single write**: port 0 write addr 13'h0123 data 8'hA5 → `drv_start` one pulse with `drv_re`=0 and the address/data, then `ack0`.
- **Read-back**: port 1 read of 13'h0123 → `ack1` with `rdata1`=8'hA5; `rdata0` unchanged.
- **Contention**: both ports request reads on the same cycle with both held → grants alternate 0,1,0,1 over four transactions, one ack per transaction.
- **Reset mid-op**: `reset` asserted in BUSY → next cycle `busy`=0, `drv_start`=0, `drv_re`=1, no ack.
- **Timeout**: with `SRAM_ARB_TIMEOUT_EN` and `TIMEOUT`=8, the driver model holds ready low → `ack0`=`err0`=1 exactly 8 cycles after BUSY entry, `rdata0`=8'h00.
- **Timeout disabled**: without the macro, a stuck driver → no ack after 10000 cycles, `err0`/`err1` stay 0.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
package sram_arb_pkg;

   localparam int SRAM_ADDR_W = 13;
   localparam int SRAM_DATA_W = 8;

   localparam logic PORT_SERIAL = 1'b0;
   localparam logic PORT_SCAN   = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_ACKWAIT,
      ST_BUSY,
      ST_DONE
   } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick; the 'last' history is owned by the caller.
module rr_arbiter2
   import sram_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant_idx,
   output logic       grant_valid
);

   always_comb begin
      grant_valid = |req;
      grant_idx   = PORT_SERIAL;
      if (req[0] && req[1]) begin
         grant_idx = ~last;
      end else if (req[1]) begin
         grant_idx = PORT_SCAN;
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one sram_driver between a serial and a scan requester.
// Optional driver-hang timeout is enabled by defining SRAM_ARB_TIMEOUT_EN.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int TIMEOUT = 1023
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req0,
   input  logic                   req1,
   input  logic                   we0,
   input  logic                   we1,
   input  logic [SRAM_ADDR_W-1:0] addr0,
   input  logic [SRAM_ADDR_W-1:0] addr1,
   input  logic [SRAM_DATA_W-1:0] wdata0,
   input  logic [SRAM_DATA_W-1:0] wdata1,
   output logic                   ack0,
   output logic                   ack1,
   output logic [SRAM_DATA_W-1:0] rdata0,
   output logic [SRAM_DATA_W-1:0] rdata1,
   output logic                   err0,
   output logic                   err1,
   output logic                   busy,
   output logic                   drv_start,
   output logic                   drv_re,
   output logic [SRAM_ADDR_W-1:0] drv_address,
   output logic [SRAM_DATA_W-1:0] drv_data_write,
   input  logic                   drv_ready,
   input  logic [SRAM_DATA_W-1:0] drv_data_read
);

   arb_state_e             state_q, state_d;
   logic                   last_q, last_d;
   logic                   grant_q, grant_d;
   logic                   re_q, re_d;
   logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
   logic [SRAM_DATA_W-1:0] wdata_q, wdata_d;
   logic [SRAM_DATA_W-1:0] rdata0_q, rdata0_d;
   logic [SRAM_DATA_W-1:0] rdata1_q, rdata1_d;
   logic                   start_q, busy_q;
   logic                   ack0_q, ack0_d;
   logic                   ack1_q, ack1_d;
   logic                   timeout_hit;
   logic                   gnt_idx, gnt_valid;

   rr_arbiter2 u_rr (
      .req         ({req1, req0}),
      .last        (last_q),
      .grant_idx   (gnt_idx),
      .grant_valid (gnt_valid)
   );

`ifdef SRAM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err0_q, err1_q;

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == ST_START) begin
         cnt_d = '0;
      end else if (state_q == ST_ACKWAIT || state_q == ST_BUSY) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = |TIMEOUT;
`endif

   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      grant_d     = grant_q;
      re_d        = re_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      timeout_hit = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (drv_ready && gnt_valid) begin
               state_d = ST_START;
               grant_d = gnt_idx;
               last_d  = gnt_idx;
               if (gnt_idx == PORT_SCAN) begin
                  re_d    = ~we1;
                  addr_d  = addr1;
                  wdata_d = wdata1;
               end else begin
                  re_d    = ~we0;
                  addr_d  = addr0;
                  wdata_d = wdata0;
               end
            end
         end
         ST_START:   state_d = ST_ACKWAIT;
         // ready is only trusted from ACKWAIT on; the driver may lag start by a cycle
         ST_ACKWAIT: if (!drv_ready) state_d = ST_BUSY;
         ST_BUSY:    if (drv_ready) state_d = ST_DONE;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
`ifdef SRAM_ARB_TIMEOUT_EN
      if ((state_q == ST_ACKWAIT || state_q == ST_BUSY) && cnt_q == CNT_W'(TIMEOUT)) begin
         state_d     = ST_DONE;
         timeout_hit = 1'b1;
      end
`endif
   end

   // DONE lasts one cycle, so state_d == DONE marks exactly the completing edge
   always_comb begin
      ack0_d   = (state_d == ST_DONE) && (grant_q == PORT_SERIAL);
      ack1_d   = (state_d == ST_DONE) && (grant_q == PORT_SCAN);
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      if (ack0_d) begin
         if (timeout_hit) rdata0_d = '0;
         else if (re_q)   rdata0_d = drv_data_read;
      end
      if (ack1_d) begin
         if (timeout_hit) rdata1_d = '0;
         else if (re_q)   rdata1_d = drv_data_read;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         last_q   <= 1'b1;
         grant_q  <= PORT_SERIAL;
         re_q     <= 1'b1;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         grant_q  <= grant_d;
         re_q     <= re_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         start_q  <= (state_d == ST_START);
         busy_q   <= (state_d != ST_IDLE);
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
      end
   end

`ifdef SRAM_ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         err0_q <= 1'b0;
         err1_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         err0_q <= ack0_d && timeout_hit;
         err1_q <= ack1_d && timeout_hit;
      end
   end

   assign err0 = err0_q;
   assign err1 = err1_q;
`else
   assign err0 = 1'b0;
   assign err1 = 1'b0;
`endif

   assign ack0           = ack0_q;
   assign ack1           = ack1_q;
   assign rdata0         = rdata0_q;
   assign rdata1         = rdata1_q;
   assign busy           = busy_q;
   assign drv_start      = start_q;
   assign drv_re         = re_q;
   assign drv_address    = addr_q;
   assign drv_data_write = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter with a behavioural sram_driver and a transaction-level reference model.
module tb_sram_arbiter;
   import sram_arb_pkg::*;

`ifdef SRAM_ARB_TIMEOUT_EN
   localparam int TB_TIMEOUT = 8;
`else
   localparam int TB_TIMEOUT = 1023;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, we0, we1;
   logic [12:0] addr0, addr1;
   logic [7:0]  wdata0, wdata1;
   logic        ack0, ack1, err0, err1, busy;
   logic [7:0]  rdata0, rdata1;
   logic        drv_start, drv_re;
   logic [12:0] drv_address;
   logic [7:0]  drv_data_write;
   logic        drv_ready;
   logic [7:0]  drv_data_read;

   always #5 clk = ~clk;

   sram_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .err0(err0), .err1(err1), .busy(busy),
      .drv_start(drv_start), .drv_re(drv_re), .drv_address(drv_address),
      .drv_data_write(drv_data_write), .drv_ready(drv_ready), .drv_data_read(drv_data_read)
   );

   // Behavioural sram_driver: drops ready after start for drv_lat cycles, then completes.
   bit [7:0]  sram [8192];
   int        drv_lat = 2;
   bit        stuck = 1'b0;
   int        dcnt = 0;
   bit        op_re;
   bit [12:0] op_addr;
   bit [7:0]  op_wd;

   initial begin
      drv_ready     = 1'b1;
      drv_data_read = 8'h00;
   end

   always @(negedge clk) begin
      if (reset) begin
         drv_ready = 1'b1;
         dcnt      = 0;
      end else if (drv_ready && drv_start) begin
         drv_ready = 1'b0;
         dcnt      = drv_lat + 1;
         op_re     = drv_re;
         op_addr   = drv_address;
         op_wd     = drv_data_write;
      end else if (!drv_ready && !stuck) begin
         dcnt--;
         if (dcnt <= 0) begin
            if (op_re) drv_data_read = sram[op_addr];
            else       sram[op_addr] = op_wd;
            drv_ready = 1'b1;
         end
      end
   end

   // Reference model: expected memory, held read data per port, round-robin history.
   bit [7:0]  ref_mem [8192];
   bit [7:0]  exp_rd [2];
   bit        m_last;
   bit        p_we [2];
   bit [12:0] p_addr [2];
   bit [7:0]  p_wd [2];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic model_reset();
      exp_rd[0] = 8'h00;
      exp_rd[1] = 8'h00;
      m_last    = 1'b1;
   endtask

   task automatic rand_ops();
      for (int i = 0; i < 2; i++) begin
         p_we[i]   = 1'($urandom_range(0, 1));
         p_addr[i] = ($urandom_range(0, 1) == 1) ? 13'($urandom_range(0, 15)) : 13'($urandom);
         p_wd[i]   = 8'($urandom);
      end
   endtask

   task automatic wait_start(output int s, output bit ok);
      ok = 1'b0;
      s  = 0;
      for (int t = 0; t < 50 && !ok; t++) begin
         step();
         if (drv_start) begin
            ok = 1'b1;
            s  = cyc;
         end
      end
      if (!ok) check("wait_start_timeout", 0, 1);
   endtask

   // Drive one or both ports and expect ntx completions in round-robin order.
   task automatic do_round(input bit u0, input bit u1, input int ntx);
      int order [8];
      int left [2];
      int n_start, n_ack, t, q;
      left[0] = 0;
      left[1] = 0;
      for (int i = 0; i < ntx; i++) begin
         if (u0 && u1) order[i] = (i % 2 == 0) ? int'(!m_last) : int'(m_last);
         else          order[i] = u1 ? 1 : 0;
         left[order[i]]++;
      end
      req0 = u0; we0 = p_we[0]; addr0 = p_addr[0]; wdata0 = p_wd[0];
      req1 = u1; we1 = p_we[1]; addr1 = p_addr[1]; wdata1 = p_wd[1];
      n_start = 0;
      n_ack   = 0;
      t       = 0;
      while (n_ack < ntx && t < 400) begin
         step();
         t++;
         if (drv_start) begin
            if (n_start < ntx) begin
               q = order[n_start];
               check("start_re", drv_re, !p_we[q]);
               check("start_addr", drv_address, p_addr[q]);
               if (p_we[q]) check("start_wdata", drv_data_write, p_wd[q]);
            end
            n_start++;
         end
         if (ack0 || ack1) begin
            q = order[n_ack];
            check("ack_port", {ack0, ack1}, (q == 1) ? 2'b01 : 2'b10);
            check("busy_in_done", busy, 1);
            if (p_we[q]) ref_mem[p_addr[q]] = p_wd[q];
            else         exp_rd[q] = ref_mem[p_addr[q]];
            check("rdata0", rdata0, exp_rd[0]);
            check("rdata1", rdata1, exp_rd[1]);
            check("err_clear", {err0, err1}, 2'b00);
            m_last = q[0];
            left[q]--;
            if (left[q] == 0) begin
               if (q == 0) req0 = 1'b0;
               else        req1 = 1'b0;
            end
            n_ack++;
         end
      end
      if (n_ack < ntx) check("round_timeout", n_ack, ntx);
      req0 = 1'b0;
      req1 = 1'b0;
      check("start_count", n_start, ntx);
      step();
      check("idle_busy", busy, 0);
   endtask

   initial begin
      int s, a, nack, nerr;
      bit ok;
      reset = 1'b1;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      model_reset();
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_start", drv_start, 0);
      check("rst_re", drv_re, 1);
      check("rst_addr", drv_address, 0);
      check("rst_wdata", drv_data_write, 0);
      check("rst_ack", {ack0, ack1}, 2'b00);
      check("rst_err", {err0, err1}, 2'b00);
      check("rst_rdata0", rdata0, 0);
      check("rst_rdata1", rdata1, 0);
      reset = 1'b0;
      step();

      // Single write then read-back from the other port
      p_we[0] = 1'b1; p_addr[0] = 13'h0123; p_wd[0] = 8'hA5;
      do_round(1'b1, 1'b0, 1);
      p_we[1] = 1'b0; p_addr[1] = 13'h0123; p_wd[1] = 8'h00;
      do_round(1'b0, 1'b1, 1);
      check("readback_rdata1", rdata1, 8'hA5);
      check("readback_rdata0", rdata0, 8'h00);

      // Both ports hold read requests across four transactions
      p_we[0] = 1'b0; p_addr[0] = 13'h0123;
      p_we[1] = 1'b0; p_addr[1] = 13'h0007;
      do_round(1'b1, 1'b1, 4);

      for (int r = 0; r < 40; r++) begin
         drv_lat = $urandom_range(1, 4);
         rand_ops();
         case ($urandom_range(0, 2))
            0:       do_round(1'b1, 1'b0, 1);
            1:       do_round(1'b0, 1'b1, 1);
            default: do_round(1'b1, 1'b1, ($urandom_range(0, 1) == 1) ? 4 : 2);
         endcase
         repeat ($urandom_range(0, 2)) step();
      end

      // Reset while the driver is busy
      drv_lat = 6;
      req0 = 1'b1; we0 = 1'b0; addr0 = 13'h0055;
      wait_start(s, ok);
      repeat (3) step();
      reset = 1'b1;
      req0  = 1'b0;
      step();
      check("midrst_busy", busy, 0);
      check("midrst_start", drv_start, 0);
      check("midrst_re", drv_re, 1);
      check("midrst_ack", {ack0, ack1}, 2'b00);
      check("midrst_rdata0", rdata0, 0);
      reset = 1'b0;
      model_reset();
      nack = 0;
      repeat (6) begin
         step();
         if (ack0 || ack1) nack++;
      end
      check("midrst_no_ack", nack, 0);

      for (int r = 0; r < 8; r++) begin
         drv_lat = $urandom_range(1, 4);
         rand_ops();
         do_round(1'b1, 1'b1, 2);
      end

`ifdef SRAM_ARB_TIMEOUT_EN
      // Driver never returns ready: abort after TIMEOUT cycles
      drv_lat = 2;
      stuck   = 1'b1;
      req0 = 1'b1; we0 = 1'b0; addr0 = 13'h0123;
      wait_start(s, ok);
      a = 0;
      for (int t = 0; t < 60 && a == 0; t++) begin
         step();
         if (ack0) begin
            a = cyc;
            check("to_err0", err0, 1);
            check("to_rdata0", rdata0, 8'h00);
            check("to_ack1", ack1, 0);
         end
      end
      check("to_latency", a - s, 10);
      req0  = 1'b0;
      stuck = 1'b0;
      exp_rd[0] = 8'h00;
      m_last    = 1'b0;
      repeat (8) step();
      rand_ops();
      do_round(1'b1, 1'b1, 2);
`else
      // Driver never returns ready: arbiter waits indefinitely
      drv_lat = 2;
      stuck   = 1'b1;
      req0 = 1'b1; we0 = 1'b0; addr0 = 13'h0123;
      wait_start(s, ok);
      nack = 0;
      nerr = 0;
      repeat (10000) begin
         step();
         if (ack0 || ack1) nack++;
         if (err0 || err1) nerr++;
      end
      check("stuck_no_ack", nack, 0);
      check("stuck_no_err", nerr, 0);
      check("stuck_busy", busy, 1);
      req0  = 1'b0;
      reset = 1'b1;
      step();
      stuck = 1'b0;
      reset = 1'b0;
      model_reset();
      step();
      rand_ops();
      do_round(1'b1, 1'b1, 2);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
